// File: rtl/oled_frame_scheduler_if.sv
// Byte-stream, pixel-source and host-command signals of the SSD1331 frame scheduler.
// OLED_RGB565_EN widens pix_color to 16 bits.
interface oled_frame_scheduler_if;
`ifdef OLED_RGB565_EN
    localparam int PIX_W = 16;
`else
    localparam int PIX_W = 8;
`endif

    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             tx_dc;
    logic [6:0]       pix_x;
    logic [5:0]       pix_y;
    logic [PIX_W-1:0] pix_color;
    logic             cmd_valid;
    logic [7:0]       cmd_data;
    logic             cmd_last;
    logic             cmd_ready;

    modport master (
        output tx_valid, tx_data, tx_dc, pix_x, pix_y, cmd_ready,
        input  tx_ready, pix_color, cmd_valid, cmd_data, cmd_last
    );

    modport slave (
        input  tx_valid, tx_data, tx_dc, pix_x, pix_y, cmd_ready,
        output tx_ready, pix_color, cmd_valid, cmd_data, cmd_last
    );
endinterface

// File: rtl/oled_frame_scheduler.sv
// SSD1331 96x64 sequencer: panel reset, init ROM, then endless window+pixel frames with host packets
// slotted in at frame boundaries. Define OLED_RGB565_EN for 16-bit pixels sent as two bytes.
module oled_frame_scheduler #(
    parameter int RESET_CYCLES = 1000,
    parameter int PIX_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   oled_resn,
    output logic                   frame_start,
    output logic                   init_done,
    oled_frame_scheduler_if.master bus
);
    localparam logic [2:0] ST_RST_LOW  = 3'd0;
    localparam logic [2:0] ST_RST_WAIT = 3'd1;
    localparam logic [2:0] ST_INIT     = 3'd2;
    localparam logic [2:0] ST_WINDOW   = 3'd3;
    localparam logic [2:0] ST_PIXELS   = 3'd4;
    localparam logic [2:0] ST_HOST     = 3'd5;

    localparam int             RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RC_LAST  = RCW'(RESET_CYCLES - 1);
    localparam logic [1:0]     LAT_LAST = 2'(PIX_LATENCY);

    logic [2:0]     state;
    logic [RCW-1:0] rst_cnt;
    logic [5:0]     idx;
    logic [1:0]     lat_cnt;
    logic           tx_valid_r;
    logic [7:0]     tx_data_r;
    logic [6:0]     pix_x_r;
    logic [5:0]     pix_y_r;
    logic           xfer;
    logic           pix_done;
    logic [7:0]     pix_first;

    function automatic logic [7:0] init_rom(input logic [5:0] i);
        case (i)
            6'd0:  init_rom = 8'hBC;  6'd1:  init_rom = 8'hAE;  6'd2:  init_rom = 8'hA0;
`ifdef OLED_RGB565_EN
            6'd3:  init_rom = 8'h62;
`else
            6'd3:  init_rom = 8'h22;
`endif
            6'd4:  init_rom = 8'hA1;  6'd5:  init_rom = 8'h00;  6'd6:  init_rom = 8'hA2;
            6'd7:  init_rom = 8'h00;  6'd8:  init_rom = 8'hA4;  6'd9:  init_rom = 8'hA8;
            6'd10: init_rom = 8'h3F;  6'd11: init_rom = 8'hAD;  6'd12: init_rom = 8'h8E;
            6'd13: init_rom = 8'hB0;  6'd14: init_rom = 8'h00;  6'd15: init_rom = 8'hB1;
            6'd16: init_rom = 8'h74;  6'd17: init_rom = 8'hF0;  6'd18: init_rom = 8'hF0;
            6'd19: init_rom = 8'h8A;  6'd20: init_rom = 8'h64;  6'd21: init_rom = 8'h8B;
            6'd22: init_rom = 8'h78;  6'd23: init_rom = 8'h8C;  6'd24: init_rom = 8'h64;
            6'd25: init_rom = 8'hBB;  6'd26: init_rom = 8'h31;  6'd27: init_rom = 8'h81;
            6'd28: init_rom = 8'hFF;  6'd29: init_rom = 8'h82;  6'd30: init_rom = 8'hFF;
            6'd31: init_rom = 8'h83;  6'd32: init_rom = 8'hFF;  6'd33: init_rom = 8'hBE;
            6'd34: init_rom = 8'h3E;  6'd35: init_rom = 8'h87;  6'd36: init_rom = 8'h06;
            default: init_rom = 8'hAF;
        endcase
    endfunction

    // Full-screen column/row address window sent ahead of every frame.
    function automatic logic [7:0] window_byte(input logic [2:0] i);
        case (i)
            3'd0:    window_byte = 8'h15;
            3'd2:    window_byte = 8'h5F;
            3'd3:    window_byte = 8'h75;
            3'd5:    window_byte = 8'h3F;
            default: window_byte = 8'h00;
        endcase
    endfunction

`ifdef OLED_RGB565_EN
    logic low_phase;
    assign pix_done  = xfer && low_phase;
    assign pix_first = bus.pix_color[15:8];
`else
    assign pix_done  = xfer;
    assign pix_first = bus.pix_color;
`endif

    assign xfer      = tx_valid_r && bus.tx_ready;
    assign bus.pix_x = pix_x_r;
    assign bus.pix_y = pix_y_r;

    // HOST hands the transmitter straight to the host; elsewhere the registered byte drives it.
    always_comb begin
        oled_resn   = (state != ST_RST_LOW);
        frame_start = (state == ST_WINDOW) && (idx == 6'd0) && xfer;
        if (state == ST_HOST) begin
            bus.tx_valid  = bus.cmd_valid;
            bus.tx_data   = bus.cmd_data;
            bus.tx_dc     = 1'b0;
            bus.cmd_ready = bus.tx_ready;
        end else begin
            bus.tx_valid  = tx_valid_r;
            bus.tx_data   = tx_data_r;
            bus.tx_dc     = (state == ST_PIXELS);
            bus.cmd_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RST_LOW;
            rst_cnt    <= '0;
            idx        <= '0;
            lat_cnt    <= '0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= '0;
            pix_x_r    <= '0;
            pix_y_r    <= '0;
            init_done  <= 1'b0;
`ifdef OLED_RGB565_EN
            low_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RST_LOW: begin
                    if (rst_cnt == RC_LAST) begin
                        rst_cnt <= '0;
                        state   <= ST_RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_RST_WAIT: begin
                    if (rst_cnt == RC_LAST) begin
                        rst_cnt    <= '0;
                        state      <= ST_INIT;
                        idx        <= '0;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= init_rom(6'd0);
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (xfer) begin
                        if (idx == 6'd37) begin
                            init_done <= 1'b1;
                            state     <= ST_WINDOW;
                            idx       <= '0;
                            tx_data_r <= window_byte(3'd0);
                            pix_x_r   <= '0;
                            pix_y_r   <= '0;
                        end else begin
                            idx       <= idx + 6'd1;
                            tx_data_r <= init_rom(idx + 6'd1);
                        end
                    end
                end
                ST_WINDOW: begin
                    if (xfer) begin
                        if (idx == 6'd5) begin
                            state      <= ST_PIXELS;
                            tx_valid_r <= 1'b0;
                            lat_cnt    <= '0;
                        end else begin
                            idx       <= idx + 6'd1;
                            tx_data_r <= window_byte(idx[2:0] + 3'd1);
                        end
                    end
                end
                ST_PIXELS: begin
                    // Wait out the pixel source latency after every address change before sampling.
                    if (!tx_valid_r) begin
                        if (lat_cnt == LAT_LAST) begin
                            tx_valid_r <= 1'b1;
                            tx_data_r  <= pix_first;
                            lat_cnt    <= '0;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end else if (pix_done) begin
                        tx_valid_r <= 1'b0;
`ifdef OLED_RGB565_EN
                        low_phase  <= 1'b0;
`endif
                        if (pix_x_r == 7'd95) begin
                            pix_x_r <= '0;
                            if (pix_y_r == 6'd63) begin
                                pix_y_r <= '0;
                                if (bus.cmd_valid) begin
                                    state <= ST_HOST;
                                end else begin
                                    state      <= ST_WINDOW;
                                    idx        <= '0;
                                    tx_valid_r <= 1'b1;
                                    tx_data_r  <= window_byte(3'd0);
                                end
                            end else begin
                                pix_y_r <= pix_y_r + 6'd1;
                            end
                        end else begin
                            pix_x_r <= pix_x_r + 7'd1;
                        end
                    end
`ifdef OLED_RGB565_EN
                    else if (xfer) begin
                        low_phase <= 1'b1;
                        tx_data_r <= bus.pix_color[7:0];
                    end
`endif
                end
                ST_HOST: begin
                    if (bus.cmd_valid && bus.tx_ready && bus.cmd_last) begin
                        state      <= ST_WINDOW;
                        idx        <= '0;
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= window_byte(3'd0);
                    end
                end
                default: state <= ST_RST_LOW;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Directed bench for oled_frame_scheduler: reset timing, init ROM, window, full frames, host packet,
// back-pressure stability and mid-frame reset.
`timescale 1ns/1ps
module tb_oled_frame_scheduler;
    localparam int RC = 20;
    localparam logic [7:0] WIN_EXP [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
    localparam logic [7:0] ROM_EXP [38] = '{
        8'hBC, 8'hAE, 8'hA0, 8'h22, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8,
        8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h00, 8'hB1, 8'h74, 8'hF0, 8'hF0, 8'h8A,
        8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h31, 8'h81, 8'hFF, 8'h82,
        8'hFF, 8'h83, 8'hFF, 8'hBE, 8'h3E, 8'h87, 8'h06, 8'hAF};
`ifdef OLED_RGB565_EN
    localparam logic [7:0] ROM3_EXP = 8'h62;
`else
    localparam logic [7:0] ROM3_EXP = 8'h22;
`endif

    logic clk = 1'b0;
    logic reset;
    logic oled_resn, frame_start, init_done;

    int   checks = 0;
    int   errors = 0;
    logic nxt_reset, nxt_cmd_valid, nxt_cmd_last;
    logic [7:0] nxt_cmd_data;
    bit   rand_ready, consumed, stalled;
    logic [7:0] held_data;
    logic held_dc;
    int   ready_seen;

    oled_frame_scheduler_if bus();

    oled_frame_scheduler #(.RESET_CYCLES(RC), .PIX_LATENCY(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .oled_resn   (oled_resn),
        .frame_start (frame_start),
        .init_done   (init_done),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    // Pixel source with one clock of latency from address to color.
    always @(posedge clk) begin
`ifdef OLED_RGB565_EN
        bus.pix_color <= 16'hF81F;
`else
        bus.pix_color <= {bus.pix_x[2:0], bus.pix_y[4:0]};
`endif
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample shortly after, check back-pressure hold.
    task automatic apply_stimulus();
        @(negedge clk);
        reset         = nxt_reset;
        bus.cmd_valid = nxt_cmd_valid;
        bus.cmd_data  = nxt_cmd_data;
        bus.cmd_last  = nxt_cmd_last;
        bus.tx_ready  = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        #1;
        if (stalled) begin
            check_output("hold_valid", bus.tx_valid, 1);
            check_output("hold_data", bus.tx_data, held_data);
            check_output("hold_dc", bus.tx_dc, held_dc);
        end
        stalled   = bus.tx_valid && !bus.tx_ready;
        held_data = bus.tx_data;
        held_dc   = bus.tx_dc;
        if (bus.cmd_ready) ready_seen++;
        consumed = 1'b0;
    endtask

    task automatic next_byte(output logic [7:0] d, output logic dc, output logic fs);
        int n = 0;
        while (!(bus.tx_valid && bus.tx_ready && !consumed) && n < 200) begin
            apply_stimulus();
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL byte_timeout: no transfer within 200 cycles, required one");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "[TB] aborting after timeout");
        end
        d  = bus.tx_data;
        dc = bus.tx_dc;
        fs = frame_start;
        consumed = 1'b1;
    endtask

    task automatic measure_reset();
        int n = 0;
        while (!oled_resn && n < 5 * RC) begin
            n++;
            apply_stimulus();
        end
        check_output("resn_low_cycles", n, RC);
        n = 0;
        while (oled_resn && !bus.tx_valid && n < 5 * RC) begin
            n++;
            apply_stimulus();
        end
        check_output("resn_high_wait", n, RC);
    endtask

    task automatic init_seq();
        logic [7:0] d;
        logic dc, fs;
        for (int i = 0; i < 38; i++) begin
            next_byte(d, dc, fs);
            check_output($sformatf("init_byte%0d", i), d, (i == 3) ? ROM3_EXP : ROM_EXP[i]);
            check_output("init_dc", dc, 0);
            if (i == 37) check_output("init_done_before_af", init_done, 0);
        end
        apply_stimulus();
        check_output("init_done_after_af", init_done, 1);
    endtask

    task automatic get_window();
        logic [7:0] d;
        logic dc, fs;
        for (int i = 0; i < 6; i++) begin
            next_byte(d, dc, fs);
            check_output($sformatf("win_byte%0d", i), d, WIN_EXP[i]);
            check_output("win_dc", dc, 0);
            check_output($sformatf("frame_start%0d", i), fs, (i == 0) ? 1 : 0);
        end
    endtask

    task automatic get_pixel(input int x, input int y);
        logic [7:0] d;
        logic dc, fs;
`ifdef OLED_RGB565_EN
        next_byte(d, dc, fs);
        check_output("pix_hi", {d, dc}, {8'hF8, 1'b1});
        next_byte(d, dc, fs);
        check_output("pix_lo", {d, dc}, {8'h1F, 1'b1});
`else
        next_byte(d, dc, fs);
        check_output("pix_data", {d, dc}, {x[2:0], y[4:0], 1'b1});
`endif
        check_output("pix_addr", {bus.pix_x, bus.pix_y}, {x[6:0], y[5:0]});
    endtask

    initial begin
        logic [7:0] d;
        logic dc, fs;
        nxt_reset = 1'b1; nxt_cmd_valid = 1'b0; nxt_cmd_data = 8'h00; nxt_cmd_last = 1'b0;
        reset = 1'b1; bus.tx_ready = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.cmd_last = 1'b0;
        rand_ready = 1'b0; consumed = 1'b1; stalled = 1'b0; ready_seen = 0;

        repeat (3) apply_stimulus();
        check_output("rst_oled_resn", oled_resn, 0);
        check_output("rst_tx_valid", bus.tx_valid, 0);
        check_output("rst_tx_data", bus.tx_data, 0);
        check_output("rst_tx_dc", bus.tx_dc, 0);
        check_output("rst_pix", {bus.pix_x, bus.pix_y}, 0);
        check_output("rst_cmd_ready", bus.cmd_ready, 0);
        check_output("rst_frame_start", frame_start, 0);
        check_output("rst_init_done", init_done, 0);

        nxt_reset = 1'b0;
        apply_stimulus();
        measure_reset();
        init_seq();
        get_window();

        // Frame 1: host packet requested mid-frame must wait for the frame boundary.
        for (int p = 0; p < 6144; p++) begin
            if (p == 100) begin
                nxt_cmd_valid = 1'b1; nxt_cmd_data = 8'h81; nxt_cmd_last = 1'b0;
                ready_seen = 0;
            end
            get_pixel(p % 96, p / 96);
        end
        check_output("cmd_ready_mid_frame", ready_seen, 0);

        next_byte(d, dc, fs);
        check_output("host_byte0", {d, dc}, {8'h81, 1'b0});
        check_output("host_cmd_ready", bus.cmd_ready, 1);
        nxt_cmd_data = 8'h40; nxt_cmd_last = 1'b1;
        next_byte(d, dc, fs);
        check_output("host_byte1", {d, dc}, {8'h40, 1'b0});
        nxt_cmd_valid = 1'b0; nxt_cmd_last = 1'b0;
        get_window();

        // Frame 2 under random back-pressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 6144; p++) get_pixel(p % 96, p / 96);
        rand_ready = 1'b0;

        // Frame 3: reset lands while pixel (10,5) is being offered.
        get_window();
        for (int p = 0; p < 490; p++) get_pixel(p % 96, p / 96);
        apply_stimulus();
        apply_stimulus();
        nxt_reset = 1'b1;
        apply_stimulus();
        check_output("pre_rst_valid", bus.tx_valid, 1);
        check_output("pre_rst_addr", {bus.pix_x, bus.pix_y}, {7'd10, 6'd5});
        nxt_reset = 1'b0;
        apply_stimulus();
        check_output("mid_rst_tx_valid", bus.tx_valid, 0);
        check_output("mid_rst_oled_resn", oled_resn, 0);
        check_output("mid_rst_init_done", init_done, 0);
        check_output("mid_rst_pix", {bus.pix_x, bus.pix_y}, 0);
        measure_reset();
        init_seq();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
